// File: rtl/wallace_reduce_pipe.sv
// Pipelined Wallace-tree reducer for RISC-V MUL/MULH/MULHSU/MULHU: emits a carry-save pair.
// Define WALLACE_MID_REG_EN to add a register after the level that halves the row count (latency 2).
module wallace_reduce_pipe #(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [1:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   sum_vec,
  output logic [2*N-1:0]   carry_vec,
  output logic             hi_sel
);

  localparam int unsigned W    = 2 * N;
  localparam int unsigned ROWS = N + 2;
  localparam int unsigned IW   = $clog2(ROWS);

  typedef logic [W-1:0] rows_t [ROWS];

  // Rows remaining after lvl levels of 3:2 compression.
  function automatic int unsigned rows_at(input int unsigned lvl);
    int unsigned r;
    r = ROWS;
    for (int unsigned i = 0; i < lvl; i++) r = (r / 3) * 2 + r % 3;
    return r;
  endfunction

  function automatic int unsigned num_levels();
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < ROWS; i++) if (rows_at(l) > 2) l++;
    return l;
  endfunction

  function automatic int unsigned mid_level();
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < ROWS; i++) if (rows_at(m) > ROWS / 2) m++;
    return m;
  endfunction

  localparam int unsigned LVLS = num_levels();

  // Apply Wallace levels lo..hi-1; every group of three rows becomes a sum row and a shifted carry row.
  function automatic rows_t reduce(input rows_t in_rows, input int unsigned lo, input int unsigned hi);
    rows_t        cur;
    rows_t        nxt;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] maj;
    int unsigned  n;
    int unsigned  g3;
    int unsigned  rem;
    cur = in_rows;
    n   = rows_at(lo);
    for (int unsigned l = lo; l < hi; l++) begin
      nxt = '{default: '0};
      g3  = n / 3;
      rem = n % 3;
      for (int unsigned g = 0; g < ROWS / 3; g++) begin
        if (g < g3) begin
          x   = cur[IW'(3 * g)];
          y   = cur[IW'(3 * g + 1)];
          z   = cur[IW'(3 * g + 2)];
          maj = (x & y) | (x & z) | (y & z);
          nxt[IW'(2 * g)]     = x ^ y ^ z;
          nxt[IW'(2 * g + 1)] = {maj[W-2:0], 1'b0};
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (r < rem) nxt[IW'(2 * g3 + r)] = cur[IW'(3 * g3 + r)];
      end
      cur = nxt;
      n   = 2 * g3 + rem;
    end
    return cur;
  endfunction

  // Partial products: rows 0..N-1 from b[N-1:0], row N subtracts the extended sign of b, row N+1 is its +1.
  logic         a_sx;
  logic         b_sx;
  logic [W-1:0] a_ext;
  logic         hi_d;
  rows_t        pp;

  always_comb begin
    a_sx  = (op != 2'b11) & a[N-1];
    b_sx  = ~op[1] & b[N-1];
    a_ext = {{N{a_sx}}, a};
    hi_d  = (op != 2'b00);
    pp    = '{default: '0};
    for (int unsigned j = 0; j < N; j++) pp[IW'(j)] = b[j] ? (a_ext << j) : '0;
    pp[IW'(N)]     = b_sx ? ~{a_ext[N-1:0], {N{1'b0}}} : '0;
    pp[IW'(N + 1)] = W'(b_sx);
  end

  logic         out_valid_q;
  logic [W-1:0] sum_q;
  logic [W-1:0] carry_q;
  logic         hi_q;
  logic         out_stage_ready;
  rows_t        fin;
  logic [W-1:0] sum_d;
  logic [W-1:0] carry_d;

  assign out_stage_ready = ~out_valid_q | out_ready;

`ifdef WALLACE_MID_REG_EN
  localparam int unsigned MID = mid_level();

  rows_t mid_d;
  rows_t mid_q;
  logic  mid_v_q;
  logic  mid_hi_q;
  logic  mid_ready;

  assign mid_ready = ~mid_v_q | out_stage_ready;
  assign in_ready  = ~flush & mid_ready;

  always_comb begin
    mid_d   = reduce(pp, 0, MID);
    fin     = reduce(mid_q, MID, LVLS);
    sum_d   = fin[0];
    carry_d = fin[1];
  end

  // Mid-tree stage followed by the output stage; flush empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_v_q     <= 1'b0;
      mid_hi_q    <= 1'b0;
      mid_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      hi_q        <= 1'b0;
    end else if (flush) begin
      mid_v_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (mid_ready) begin
        mid_v_q <= in_valid;
        if (in_valid) begin
          mid_q    <= mid_d;
          mid_hi_q <= hi_d;
        end
      end
      if (out_stage_ready) begin
        out_valid_q <= mid_v_q;
        if (mid_v_q) begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          hi_q    <= mid_hi_q;
        end
      end
    end
  end
`else
  assign in_ready = ~flush & out_stage_ready;

  always_comb begin
    fin     = reduce(pp, 0, LVLS);
    sum_d   = fin[0];
    carry_d = fin[1];
  end

  // Single output stage; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      hi_q        <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_stage_ready) begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        hi_q    <= hi_d;
      end
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign sum_vec   = sum_q;
  assign carry_vec = carry_q;
  assign hi_sel    = hi_q;

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Bench for wallace_reduce_pipe: reference multiply model plus directed handshake/flush/reset scenarios.
module tb_wallace_reduce_pipe;

`ifdef WALLACE_MID_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] sum_vec;
  logic [63:0] carry_vec;
  logic        hi_sel;

  wallace_reduce_pipe #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .sum_vec(sum_vec), .carry_vec(carry_vec), .hi_sel(hi_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] p;
    logic        hi;
    int unsigned c;
  } ent_t;

  ent_t        q[$];
  ent_t        got[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  logic        hold_v = 1'b0;
  logic [128:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  // Full product of the extended operands, taken mod 2^64.
  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mop);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (mop != 2'b11 && ma[31]) ? {32'hFFFF_FFFF, ma} : {32'h0, ma};
    eb = (mop[1] == 1'b0 && mb[31]) ? {32'hFFFF_FFFF, mb} : {32'h0, mb};
    return ea * eb;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Per-cycle compare against the model queue; also tracks handshakes, flush and reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 64'(out_valid), 64'd0);
        end else begin
          chk("product", sum_vec + carry_vec, q[0].p);
          chk("hi_sel", 64'(hi_sel), 64'(q[0].hi));
        end
        if (hold_v) chk("hold_stable", 64'({sum_vec, carry_vec, hi_sel} != held), 64'd0);
      end
      if (out_valid && out_ready) begin
        got.push_back('{p: sum_vec + carry_vec, hi: hi_sel, c: cyc});
        if (q.size() != 0) void'(q.pop_front());
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v = 1'b1;
        held   = {sum_vec, carry_vec, hi_sel};
      end else begin
        hold_v = 1'b0;
      end
      if (flush) begin
        q.delete();
        hold_v = 1'b0;
      end else if (in_valid && in_ready) begin
        q.push_back('{p: model(a, b, op), hi: (op != 2'b00), c: cyc});
      end
    end
  end

  // Offer one beat (called just after a rising edge); returns just after the accepting edge.
  task automatic beat(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top);
    a = ta; b = tb; op = top; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        last_acc = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    chk("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (got.size() >= n) break;
    end
    chk("drain_count", 64'(got.size() >= n), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [31:0] ma[8]  = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                          32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
  logic [31:0] mb[8]  = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                          32'h8000_0000, 32'h8000_0000, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
  logic [1:0]  mop[8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  logic [29:0] rdy_pat = 30'b1011_0010_1110_0101_1001_1100_0110_11;

  initial begin
    int base;
    int acc0;

    // Reset values
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum_vec, 64'd0);
    chk("rst_carry", carry_vec, 64'd0);
    chk("rst_hi", 64'(hi_sel), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // All-ones operands under each op
    base = got.size();
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    idle();
    wait_got(base + 4);
    chk("mulhu_ones", got[base].p, 64'hFFFF_FFFE_0000_0001);
    chk("mulhu_hi", 64'(got[base].hi), 64'd1);
    chk("mulh_ones", got[base+1].p, 64'h0000_0000_0000_0001);
    chk("mulhsu_ones", got[base+2].p, 64'hFFFF_FFFF_0000_0001);
    chk("mul_ones_lo", {32'h0, got[base+3].p[31:0]}, 64'h1);
    chk("mul_hi", 64'(got[base+3].hi), 64'd0);

    // Back-to-back beats, one result per cycle after the latency
    @(posedge clk); #1;
    base = got.size();
    beat(32'd3, 32'd5, 2'b00);
    acc0 = int'(last_acc);
    beat(32'd7, 32'd9, 2'b00);
    beat(32'h8000_0000, 32'd2, 2'b01);
    idle();
    wait_got(base + 3);
    chk("b2b_0", got[base].p, 64'd15);
    chk("b2b_1", got[base+1].p, 64'd63);
    chk("b2b_2", got[base+2].p, 64'hFFFF_FFFF_0000_0000);
    chk("b2b_latency", 64'(int'(got[base].c) - acc0), 64'(LAT));
    chk("b2b_gap1", 64'(got[base+1].c - got[base].c), 64'd1);
    chk("b2b_gap2", 64'(got[base+2].c - got[base+1].c), 64'd1);

    // Stall with a full pipe, then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = got.size();
    beat(32'd1, 32'd1, 2'b00);
    if (LAT > 1) beat(32'd2, 32'd3, 2'b11);
    a = (LAT > 1) ? 32'hFFFF_FFFE : 32'd2;
    b = 32'd3;
    op = (LAT > 1) ? 2'b01 : 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    beat(a, b, op);
    idle();
    wait_got(base + LAT + 1);
    chk("stall_0", got[base].p, 64'd1);
    chk("stall_1", got[base+1].p, 64'd6);
    chk("stall_1_hi", 64'(got[base+1].hi), 64'd1);
    if (LAT > 1) chk("stall_2", got[base+2].p, 64'hFFFF_FFFF_FFFF_FFFA);

    // Flush with beats in flight and a beat offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = got.size();
    beat(32'd11, 32'd13, 2'b00);
    if (LAT > 1) beat(32'd17, 32'd19, 2'b00);
    a = 32'd23; b = 32'd29; op = 2'b00; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_no_emerge", 64'(got.size()), 64'(base));

    // Asynchronous reset mid-flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = got.size();
    beat(32'd5, 32'd5, 2'b00);
    idle();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_sum", sum_vec, 64'd0);
    chk("arst_carry", carry_vec, 64'd0);
    chk("arst_hi", 64'(hi_sel), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    chk("arst_no_stale", 64'(got.size()), 64'(base));

    // Mixed operands with a throttled consumer
    @(posedge clk); #1;
    base = got.size();
    fork
      begin
        for (int i = 0; i < 8; i++) beat(ma[i], mb[i], mop[i]);
        idle();
      end
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = rdy_pat[k];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_got(base + 8);
    chk("mixed_minmax", got[base+3].p, 64'hC000_0000_8000_0000);
    chk("mixed_hu_top", got[base+5].p, 64'h4000_0000_0000_0000);
    repeat (4) @(negedge clk);
    chk("model_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
